// File: rtl/mux_4_1_rr_pkg.sv
// rtl/mux_4_1_rr_pkg.sv - shared types and round-robin pick helper for mux_4_1_rr
package mux_4_1_rr_pkg;

   localparam int CH   = 4;
   localparam int SELW = 2;

   typedef logic [SELW-1:0] sel_t;

   typedef struct packed {
      logic found;
      sel_t sel;
   } pick_t;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } lock_state_t;

   // Scan from the highest offset down so the lowest offset from ptr wins.
   function automatic pick_t rr_pick(input logic [CH-1:0] req, input sel_t ptr);
      pick_t r;
      sel_t  k;
      r = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         k = ptr + sel_t'(i);
         if (req[k]) begin
            r.found = 1'b1;
            r.sel   = k;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_4_1_rr_arbiter.sv
// rtl/mux_4_1_rr_arbiter.sv - rr_arbiter_4: combinational grant, registered ptr and packet lock
// Packet lock exists only when MUX_4_1_RR_LAST_EN is defined.
module rr_arbiter_4
   import mux_4_1_rr_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH-1:0]   x_valid,
`ifdef MUX_4_1_RR_LAST_EN
   input  logic [CH-1:0]   x_last,
`endif
   input  logic            xfer,
   output logic            gnt_found,
   output logic [SELW-1:0] gnt_sel
);

   logic [SELW-1:0] ptr_q, ptr_d;
   logic [CH-1:0]   eligible;
   pick_t           pick;

`ifdef MUX_4_1_RR_LAST_EN
   lock_state_t     state_q, state_d;
   logic [SELW-1:0] lock_ch_q, lock_ch_d;
`endif

   always_comb begin
      eligible = x_valid;
`ifdef MUX_4_1_RR_LAST_EN
      if (state_q == ST_LOCKED) begin
         eligible = x_valid & (4'b0001 << lock_ch_q);
      end
`endif
      pick = rr_pick(eligible, ptr_q);
   end

   assign gnt_found = pick.found;
   assign gnt_sel   = pick.sel;

   always_comb begin
      ptr_d = ptr_q;
`ifdef MUX_4_1_RR_LAST_EN
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      // Mid-packet beats keep ptr so the packet's owner is not skipped over.
      if (xfer) begin
         if (x_last[gnt_sel]) begin
            state_d = ST_IDLE;
            ptr_d   = gnt_sel + 2'd1;
         end else begin
            state_d   = ST_LOCKED;
            lock_ch_d = gnt_sel;
         end
      end
`else
      if (xfer) begin
         ptr_d = gnt_sel + 2'd1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
`ifdef MUX_4_1_RR_LAST_EN
         state_q   <= ST_IDLE;
         lock_ch_q <= '0;
`endif
      end else begin
         ptr_q <= ptr_d;
`ifdef MUX_4_1_RR_LAST_EN
         state_q   <= state_d;
         lock_ch_q <= lock_ch_d;
`endif
      end
   end

endmodule

// File: rtl/mux_4_1_rr.sv
// rtl/mux_4_1_rr.sv - registered 4:1 round-robin stream mux tagging beats with source index
// Packet mode (x_last/y_last, channel lock) enabled by defining MUX_4_1_RR_LAST_EN.
module mux_4_1_rr
   import mux_4_1_rr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH-1:0]       x_valid,
   output logic [CH-1:0]       x_ready,
   input  logic [CH*WIDTH-1:0] x_data,
`ifdef MUX_4_1_RR_LAST_EN
   input  logic [CH-1:0]       x_last,
   output logic                y_last,
`endif
   output logic                y_valid,
   input  logic                y_ready,
   output logic [WIDTH-1:0]    y_data,
   output logic [SELW-1:0]     y_sel
);

   logic            load;
   logic            xfer;
   logic            gnt_found;
   logic [SELW-1:0] gnt_sel;

   logic             y_valid_q, y_valid_d;
   logic [WIDTH-1:0] y_data_q, y_data_d;
   logic [SELW-1:0]  y_sel_q, y_sel_d;
`ifdef MUX_4_1_RR_LAST_EN
   logic             y_last_q, y_last_d;
`endif

   assign load = !y_valid_q || y_ready;
   // rst_n gates the handshake so no upstream beat is consumed during reset.
   assign xfer = rst_n && load && gnt_found;

   rr_arbiter_4 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .x_valid   (x_valid),
`ifdef MUX_4_1_RR_LAST_EN
      .x_last    (x_last),
`endif
      .xfer      (xfer),
      .gnt_found (gnt_found),
      .gnt_sel   (gnt_sel)
   );

   always_comb begin
      x_ready = '0;
      if (xfer) begin
         x_ready[gnt_sel] = 1'b1;
      end
   end

   always_comb begin
      y_valid_d = y_valid_q;
      y_data_d  = y_data_q;
      y_sel_d   = y_sel_q;
`ifdef MUX_4_1_RR_LAST_EN
      y_last_d  = y_last_q;
`endif
      if (load) begin
         y_valid_d = gnt_found;
         if (gnt_found) begin
            y_data_d = x_data[gnt_sel*WIDTH +: WIDTH];
            y_sel_d  = gnt_sel;
`ifdef MUX_4_1_RR_LAST_EN
            y_last_d = x_last[gnt_sel];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_valid_q <= 1'b0;
         y_data_q  <= '0;
         y_sel_q   <= '0;
`ifdef MUX_4_1_RR_LAST_EN
         y_last_q  <= 1'b0;
`endif
      end else begin
         y_valid_q <= y_valid_d;
         y_data_q  <= y_data_d;
         y_sel_q   <= y_sel_d;
`ifdef MUX_4_1_RR_LAST_EN
         y_last_q  <= y_last_d;
`endif
      end
   end

   assign y_valid = y_valid_q;
   assign y_data  = y_data_q;
   assign y_sel   = y_sel_q;
`ifdef MUX_4_1_RR_LAST_EN
   assign y_last  = y_last_q;
`endif

endmodule

// File: tb/tb_mux_4_1_rr.sv
// tb/tb_mux_4_1_rr.sv - self-checking bench for mux_4_1_rr with a behavioural arbitration model
// Packet-mode steps run when MUX_4_1_RR_LAST_EN is defined.
module tb_mux_4_1_rr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  x_valid;
   logic [3:0]  x_ready;
   logic [31:0] x_data;
   logic        y_valid;
   logic        y_ready;
   logic [7:0]  y_data;
   logic [1:0]  y_sel;
`ifdef MUX_4_1_RR_LAST_EN
   logic [3:0]  x_last;
   logic        y_last;
   bit          m_last;
`endif

   int total = 0;
   int bad   = 0;

   bit       m_valid;
   bit [7:0] m_data;
   int       m_sel;
   int       m_ptr;
   bit       m_locked;
   int       m_lock_ch;

   always #5 clk = ~clk;

   mux_4_1_rr #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .x_data  (x_data),
`ifdef MUX_4_1_RR_LAST_EN
      .x_last  (x_last),
      .y_last  (y_last),
`endif
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_data  (y_data),
      .y_sel   (y_sel)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_valid   = 1'b0;
      m_data    = 8'h00;
      m_sel     = 0;
      m_ptr     = 0;
      m_locked  = 1'b0;
      m_lock_ch = 0;
`ifdef MUX_4_1_RR_LAST_EN
      m_last    = 1'b0;
`endif
   endtask

   // First requesting channel counting up from ptr, restricted to the owner while a packet is open.
   function automatic int m_grant(input logic [3:0] v);
      int k;
      for (int i = 0; i < 4; i++) begin
         k = (m_ptr + i) % 4;
         if (v[k] && (!m_locked || k == m_lock_ch)) return k;
      end
      return -1;
   endfunction

   task automatic check_outs(input string tag);
      chk({tag, ".y_valid"}, 32'(y_valid), 32'(m_valid));
      chk({tag, ".y_data"},  32'(y_data),  32'(m_data));
      chk({tag, ".y_sel"},   32'(y_sel),   32'(m_sel));
`ifdef MUX_4_1_RR_LAST_EN
      chk({tag, ".y_last"},  32'(y_last),  32'(m_last));
`endif
   endtask

   task automatic step(input string tag);
      int         g;
      bit         load;
      logic [3:0] exp_rdy;
      #1;
      load    = !m_valid || y_ready;
      g       = m_grant(x_valid);
      exp_rdy = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk({tag, ".x_ready"}, 32'(x_ready), 32'(exp_rdy));
      @(posedge clk);
      if (load) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = x_data[g*8 +: 8];
            m_sel   = g;
`ifdef MUX_4_1_RR_LAST_EN
            m_last  = x_last[g];
            if (x_last[g]) begin
               m_locked = 1'b0;
               m_ptr    = (g + 1) % 4;
            end else begin
               m_locked  = 1'b1;
               m_lock_ch = g;
            end
`else
            m_ptr = (g + 1) % 4;
`endif
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
      check_outs(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      m_reset();
      chk({tag, ".x_ready"}, 32'(x_ready), 32'h0);
      check_outs(tag);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, ".x_ready_hold"}, 32'(x_ready), 32'h0);
      check_outs({tag, "_hold"});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b1;
      x_valid = 4'h0;
      x_data  = 32'hA3A2A1A0;
      y_ready = 1'b1;
`ifdef MUX_4_1_RR_LAST_EN
      x_last  = 4'hF;
`endif
      @(negedge clk);
      x_valid = 4'hF;
      do_reset("rst");

      for (int i = 0; i < 5; i++) begin
         step("rot");
         chk("rot.sel_seq",  32'(y_sel),  32'(i % 4));
         chk("rot.data_seq", 32'(y_data), 32'(8'hA0 + i % 4));
      end

      step("pre_bp");
      step("pre_bp");
      chk("bp.start_data", 32'(y_data), 32'hA2);
      y_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("bp");
         chk("bp.hold_data", 32'(y_data), 32'hA2);
         chk("bp.hold_sel",  32'(y_sel),  32'd2);
      end
      y_ready = 1'b1;
      step("bp_release");
      chk("bp.next_data", 32'(y_data), 32'hA3);

      do_reset("rst2");
      x_valid = 4'b0100;
      step("sparse");
      chk("sparse.sel2", 32'(y_sel), 32'd2);
      x_valid = 4'b0010;
      step("sparse_wrap");
      chk("sparse.sel1", 32'(y_sel), 32'd1);

`ifdef MUX_4_1_RR_LAST_EN
      do_reset("rst3");
      x_valid = 4'b0001;
      x_last  = 4'b1111;
      step("pkt_pre");
      x_valid = 4'b0111;
      x_last  = 4'b1101;
      step("pkt1");
      chk("pkt.b1_sel", 32'(y_sel), 32'd1);
      chk("pkt.b1_last", 32'(y_last), 32'd0);
      step("pkt2");
      chk("pkt.b2_sel", 32'(y_sel), 32'd1);
      x_last = 4'b1111;
      step("pkt3");
      chk("pkt.b3_sel", 32'(y_sel), 32'd1);
      chk("pkt.b3_last", 32'(y_last), 32'd1);
      step("pkt_after");
      chk("pkt.after_sel", 32'(y_sel), 32'd2);
      x_last = 4'b1101;
`endif

      x_valid = 4'b0010;
      step("mid_open");
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("mid_rst.x_ready", 32'(x_ready), 32'h0);
      check_outs("mid_rst");
      @(negedge clk);
      rst_n   = 1'b1;
      x_valid = 4'b0111;
`ifdef MUX_4_1_RR_LAST_EN
      x_last  = 4'b1111;
`endif
      step("mid_rel");
      chk("mid_rst.first_sel", 32'(y_sel), 32'd0);

      for (int i = 0; i < 300; i++) begin
         x_valid = 4'($urandom);
         x_data  = $urandom;
         y_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_4_1_RR_LAST_EN
         x_last  = 4'($urandom);
`endif
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
